// File: rtl/op_class_dispatch_if.sv
// Instruction dispatch bus: one input stream and two classified output streams.
// The master side feeds words and consumes heads; the slave side is the dispatcher.
interface op_class_dispatch_if #(
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;

    logic               mem_valid;
    logic               mem_ready;
    logic [INSTR_W-1:0] mem_instr;
    logic               mem_is_store;

    logic               pim_valid;
    logic               pim_ready;
    logic [INSTR_W-1:0] pim_instr;
    logic [2:0]         pim_sel;

    modport master (
        output in_valid, in_instr, mem_ready, pim_ready,
        input  in_ready, mem_valid, mem_instr, mem_is_store,
        input  pim_valid, pim_instr, pim_sel
    );

    modport slave (
        input  in_valid, in_instr, mem_ready, pim_ready,
        output in_ready, mem_valid, mem_instr, mem_is_store,
        output pim_valid, pim_instr, pim_sel
    );
endinterface

// File: rtl/op_class_dispatch.sv
// Registered opcode classifier: sorts instruction words into memory and PIM FIFOs,
// drops and counts illegal opcodes, and optionally fences type switches.
module op_class_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [W-1:0]     buf_q [DEPTH];
    logic [W-1:0]     buf_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_en;
    logic             pop_en;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign valid   = (level_q != '0);
    assign push_en = push && !full;
    assign pop_en  = pop && valid;
    assign level   = level_q;
    assign dout    = valid ? buf_q[rd_ptr_q] : '0;

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) begin
            buf_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

module op_class_dispatch #(
    parameter int INSTR_W = 32,
    parameter int OPC_MSB = 31,
    parameter int DEPTH   = 4,
    parameter int ORDERED = 1,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    op_class_dispatch_if.slave         bus,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] mem_level,
    output logic [$clog2(DEPTH+1)-1:0] pim_level,
    output logic                       illegal_err,
    output logic [CNT_W-1:0]           illegal_cnt
);
    logic [5:0]       opcode;
    logic             is_mem;
    logic             is_store;
    logic             is_pim;
    logic [2:0]       sel;
    logic             mem_full;
    logic             pim_full;
    logic             in_ready_c;
    logic             fire;
    logic             illegal_acc;
    logic             illegal_err_q, illegal_err_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    assign opcode = bus.in_instr[OPC_MSB -: 6];

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        is_pim   = 1'b0;
        sel      = 3'd0;
        case (opcode)
            6'b110000, 6'b111000, 6'b110001, 6'b111001, 6'b110010: is_mem = 1'b1;
            6'b110100, 6'b111100, 6'b110101, 6'b111101, 6'b110110: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            6'b010100: begin is_pim = 1'b1; sel = 3'd0; end
            6'b010101: begin is_pim = 1'b1; sel = 3'd1; end
            6'b010111: begin is_pim = 1'b1; sel = 3'd2; end
            6'b110011: begin is_pim = 1'b1; sel = 3'd3; end
            6'b110111: begin is_pim = 1'b1; sel = 3'd4; end
            default: ;
        endcase
    end

    // Ready looks only at the offered class and registered levels, never at the consumers.
    always_comb begin
        if (is_mem) begin
            in_ready_c = !mem_full && !((ORDERED != 0) && (pim_level != '0));
        end else if (is_pim) begin
            in_ready_c = !pim_full && !((ORDERED != 0) && (mem_level != '0));
        end else begin
            in_ready_c = 1'b1;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign fire         = bus.in_valid && in_ready_c;
    assign illegal_acc  = fire && !is_mem && !is_pim;

    op_class_fifo #(.W(INSTR_W+1), .DEPTH(DEPTH)) u_mem_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire && is_mem),
        .din   ({is_store, bus.in_instr}),
        .pop   (bus.mem_ready),
        .dout  ({bus.mem_is_store, bus.mem_instr}),
        .valid (bus.mem_valid),
        .full  (mem_full),
        .level (mem_level)
    );

    op_class_fifo #(.W(INSTR_W+3), .DEPTH(DEPTH)) u_pim_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire && is_pim),
        .din   ({sel, bus.in_instr}),
        .pop   (bus.pim_ready),
        .dout  ({bus.pim_sel, bus.pim_instr}),
        .valid (bus.pim_valid),
        .full  (pim_full),
        .level (pim_level)
    );

    // A drop coinciding with a clear restarts the count at one.
    always_comb begin
        illegal_err_d = illegal_err_q;
        illegal_cnt_d = illegal_cnt_q;
        if (illegal_acc) begin
            illegal_err_d = 1'b1;
            if (err_clr) begin
                illegal_cnt_d = CNT_W'(1);
            end else if (illegal_cnt_q != '1) begin
                illegal_cnt_d = illegal_cnt_q + 1'b1;
            end
        end else if (err_clr) begin
            illegal_err_d = 1'b0;
            illegal_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_err_q <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_err_q <= illegal_err_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal_err = illegal_err_q;
    assign illegal_cnt = illegal_cnt_q;
endmodule
